bitwise_lu: RTL and testbench



---
 rtl/bitwise_lu.sv | 82 ++++++++
 tb/tb_bitwise_lu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_lu.sv
// bitwise_lu: pipelined eight-operation bitwise logic unit with valid/ready handshakes,
// zero flag and output transfer counter.
module bitwise_lu #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [15:0]      out_count
);
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_z;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [15:0]       r_cnt;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_uv;
    logic [STAGES-1:0] w_uz;
    logic [WIDTH-1:0]  w_ud [STAGES];
    logic [WIDTH-1:0]  w_res;

    always_comb begin
        case (op)
            3'd0:    w_res = ~a;
            3'd1:    w_res = a & b;
            3'd2:    w_res = a | b;
            3'd3:    w_res = a ^ b;
            3'd4:    w_res = ~(a & b);
            3'd5:    w_res = ~(a | b);
            3'd6:    w_res = ~(a ^ b);
            default: w_res = a;
        endcase
    end

    // A stage may load whenever the consumer takes data or any stage from here down is empty.
    for (genvar i = 0; i < STAGES; i++) begin : g_st
        assign w_rdy[i] = out_ready | ~&r_v[STAGES-1:i];
        if (i == 0) begin : g_in
            assign w_uv[0] = in_valid;
            assign w_ud[0] = w_res;
            assign w_uz[0] = ~|w_res;
        end else begin : g_mv
            assign w_uv[i] = r_v[i-1];
            assign w_ud[i] = r_d[i-1];
            assign w_uz[i] = r_z[i-1];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v[i] <= 1'b0;
                r_d[i] <= '0;
                r_z[i] <= 1'b1;
            end else if (w_rdy[i]) begin
                r_v[i] <= w_uv[i];
                if (w_uv[i]) begin
                    r_d[i] <= w_ud[i];
                    r_z[i] <= w_uz[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'(out_valid & out_ready);
    end

    assign in_ready  = w_rdy[0] & ~rst;
    assign out_valid = r_v[STAGES-1];
    assign y         = r_d[STAGES-1];
    assign zero      = r_z[STAGES-1];
    assign out_count = r_cnt;
endmodule

// File: tb/tb_bitwise_lu.sv
// tb_bitwise_lu: scoreboard bench for bitwise_lu with a behavioural reference model.
module tb_bitwise_lu;
    localparam int W = 8;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0, zero;
    logic [W-1:0] a = 0, b = 0, y;
    logic [2:0] op = 0;
    logic [15:0] out_count;
    logic iv3 = 0, ir3, ov3, or3 = 0, z3;
    logic [W-1:0] a3 = 0, b3 = 0, y3;
    logic [2:0] op3 = 0;
    logic [15:0] cnt3;
    int n_chk = 0, n_fail = 0, acc = 0, xfer = 0;
    logic [15:0] exp_cnt = 0;
    logic cnt_on = 0;
    logic [W:0] sb [$];
    logic [W:0] e;
    logic [W-1:0] tbl [8] = '{8'h3A, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5};
    logic [7:0] ztbl = 8'b0110_0010;
    logic [W:0] e3 [3];
    logic [W-1:0] hold;
    int nacc;

    always #5 clk = ~clk;

    bitwise_lu #(.WIDTH(W), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero), .out_count(out_count));

    bitwise_lu #(.WIDTH(W), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .op(op3),
        .out_valid(ov3), .out_ready(or3), .y(y3), .zero(z3), .out_count(cnt3));

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] z, input logic [2:0] o);
        logic [W-1:0] r;
        case (o)
            3'd0:    r = ~x;
            3'd1:    r = x & z;
            3'd2:    r = x | z;
            3'd3:    r = x ^ z;
            3'd4:    r = ~(x & z);
            3'd5:    r = ~(x | z);
            3'd6:    r = ~(x ^ z);
            default: r = x;
        endcase
        return {r == 0, r};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cnt_on) chk("out_count", 64'(out_count), 64'(exp_cnt));
        if (rst) begin
            sb.delete();
            exp_cnt = 0;
            xfer = 0;
            acc = 0;
            cnt_on = 1;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected output: got y=%0h with empty scoreboard", y);
                end else begin
                    e = sb.pop_front();
                    chk("y", 64'(y), 64'(e[W-1:0]));
                    chk("zero", 64'(zero), 64'(e[W]));
                end
                exp_cnt++;
                xfer++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, op));
                acc++;
            end
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1;
        iv3 = 1;
        a = 8'h12;
        b = 8'h34;
        repeat (3) begin
            step;
            chk("rst in_ready", 64'(in_ready), 64'(0));
            chk("rst in_ready3", 64'(ir3), 64'(0));
            chk("rst out_valid", 64'(out_valid), 64'(0));
            chk("rst y", 64'(y), 64'(0));
            chk("rst zero", 64'(zero), 64'(1));
            chk("rst out_count", 64'(out_count), 64'(0));
        end
        rst = 0;
        in_valid = 0;
        iv3 = 0;
        step;

        out_ready = 1;
        a = 8'hC5;
        b = 8'h3A;
        for (int k = 0; k < 10; k++) begin
            in_valid = k < 8;
            op = 3'(k);
            step;
            if (k >= 1 && k <= 8) begin
                chk("sweep valid", 64'(out_valid), 64'(1));
                chk("sweep y", 64'(y), 64'(tbl[k-1]));
                chk("sweep zero", 64'(zero), 64'(ztbl[k-1]));
            end
        end
        chk("sweep count", 64'(out_count), 64'(8));

        out_ready = 0;
        in_valid = 1;
        nacc = 0;
        for (int k = 0; k < 4; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            op = 3'($urandom);
            #1;
            if (in_ready) nacc++;
            step;
        end
        chk("bp accepted", 64'(nacc), 64'(2));
        chk("bp in_ready", 64'(in_ready), 64'(0));
        chk("bp out_valid", 64'(out_valid), 64'(1));
        hold = y;
        repeat (2) step;
        chk("bp y stable", 64'(y), 64'(hold));
        in_valid = 0;
        out_ready = 1;
        for (int t = 0; t < 20 && sb.size() != 0; t++) step;
        chk("bp drained", 64'(sb.size()), 64'(0));
        step;
        chk("bp idle", 64'(out_valid), 64'(0));

        for (int k = 0; k < 3; k++) begin
            a3 = W'($urandom);
            b3 = W'($urandom);
            op3 = 3'($urandom);
            e3[k] = model(a3, b3, op3);
            iv3 = 1;
            #1;
            chk("bubble in_ready", 64'(ir3), 64'(1));
            step;
            iv3 = 0;
            if (k == 0) begin
                chk("bubble idle1 in_ready", 64'(ir3), 64'(1));
                step;
                chk("bubble idle2 in_ready", 64'(ir3), 64'(1));
                step;
                chk("bubble out_valid", 64'(ov3), 64'(1));
                chk("bubble y", 64'(y3), 64'(e3[0][W-1:0]));
                chk("bubble zero", 64'(z3), 64'(e3[0][W]));
            end
        end
        iv3 = 1;
        #1;
        chk("bubble full in_ready", 64'(ir3), 64'(0));
        iv3 = 0;
        or3 = 1;
        step;
        chk("bubble y1", 64'(y3), 64'(e3[1][W-1:0]));
        step;
        chk("bubble y2", 64'(y3), 64'(e3[2][W-1:0]));
        step;
        chk("bubble empty", 64'(ov3), 64'(0));
        chk("bubble count", 64'(cnt3), 64'(3));

        out_ready = 0;
        in_valid = 1;
        repeat (2) begin
            a = W'($urandom);
            b = W'($urandom);
            op = 3'($urandom);
            step;
        end
        in_valid = 0;
        rst = 1;
        step;
        rst = 0;
        out_ready = 1;
        repeat (3) begin
            chk("midrst out_valid", 64'(out_valid), 64'(0));
            chk("midrst out_count", 64'(out_count), 64'(0));
            step;
        end
        a = W'($urandom);
        b = W'($urandom);
        op = 3'($urandom);
        e = model(a, b, op);
        in_valid = 1;
        step;
        in_valid = 0;
        chk("midrst early", 64'(out_valid), 64'(0));
        step;
        chk("midrst latency", 64'(out_valid), 64'(1));
        chk("midrst y", 64'(y), 64'(e[W-1:0]));
        step;

        rst = 1;
        step;
        rst = 0;
        for (int c = 0; c < 90000 && (acc < 65536 || sb.size() != 0); c++) begin
            in_valid = acc < 65536 && ($urandom % 32 != 0);
            a = W'($urandom);
            b = W'($urandom);
            op = 3'($urandom);
            out_ready = $urandom % 32 != 0;
            step;
        end
        in_valid = 0;
        step;
        chk("wrap drained", 64'(sb.size()), 64'(0));
        chk("wrap transfers", 64'(xfer), 64'(65536));
        chk("wrap count", 64'(out_count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
